// File: rtl/divider.sv
// Multicycle signed restoring divider, one quotient bit per cycle, truncating toward zero.
// Optional remainder output is enabled by defining DIV_REMAINDER_EN.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    ctrl_div,
   input  logic signed [WIDTH-1:0] dividend,
   input  logic signed [WIDTH-1:0] divisor,
   output logic signed [WIDTH-1:0] quotient,
   output logic                    exception,
   output logic                    resultRDY,
   output logic                    busy,
   output logic [4:0]              state_count
`ifdef DIV_REMAINDER_EN
   ,
   output logic signed [WIDTH-1:0] remainder
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   state_t state, state_nx;

   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] d;
   logic             sign_q;
   logic             exc_pend;
`ifdef DIV_REMAINDER_EN
   logic             sign_r;
`endif

   logic             start;
   logic             div_zero;
   logic             ovf;
   logic [WIDTH+1:0] r_sh;
   logic [WIDTH+1:0] diff;

   // Magnitude as unsigned; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   // A start landing in the result-strobe cycle is still treated as busy.
   assign start    = (state == IDLE) && !resultRDY && ctrl_div;
   assign div_zero = (divisor == '0);
   assign ovf      = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
   assign busy     = (state != IDLE) || resultRDY;

   assign r_sh = {r, q[WIDTH-1]};
   assign diff = r_sh - {2'b00, d};

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (div_zero || ovf) ? DONE : RUN;
         RUN:     if (state_count == LAST_ITER) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r           <= '0;
         q           <= '0;
         d           <= '0;
         sign_q      <= 1'b0;
         exc_pend    <= 1'b0;
         quotient    <= '0;
         exception   <= 1'b0;
         resultRDY   <= 1'b0;
         state_count <= '0;
`ifdef DIV_REMAINDER_EN
         sign_r      <= 1'b0;
         remainder   <= '0;
`endif
      end else begin
         resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r           <= '0;
                  state_count <= '0;
                  d           <= abs_w(divisor);
                  exc_pend    <= div_zero || ovf;
                  exception   <= 1'b0;
`ifdef DIV_REMAINDER_EN
                  sign_r      <= dividend[WIDTH-1];
`endif
                  if (div_zero) begin
                     q      <= '0;
                     sign_q <= 1'b0;
                  end else if (ovf) begin
                     q      <= {1'b1, {(WIDTH-1){1'b0}}};
                     sign_q <= 1'b0;
                  end else begin
                     q      <= abs_w(dividend);
                     sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  end
               end
            end
            RUN: begin
               // diff's top bit is the borrow: set means restore.
               if (diff[WIDTH+1]) r <= r_sh[WIDTH:0];
               else               r <= diff[WIDTH:0];
               q           <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
               state_count <= state_count + 5'd1;
            end
            DONE: begin
               resultRDY <= 1'b1;
               quotient  <= cond_neg(sign_q, q);
               exception <= exc_pend;
`ifdef DIV_REMAINDER_EN
               remainder <= cond_neg(sign_r, r[WIDTH-1:0]);
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: latency, signed results, exceptions,
// ignored starts and mid-run reset. Remainder checks apply when DIV_REMAINDER_EN is defined.
module tb_divider;
   localparam int W = 32;

   logic                clock = 1'b0;
   logic                reset = 1'b0;
   logic                ctrl_div = 1'b0;
   logic signed [W-1:0] dividend = '0;
   logic signed [W-1:0] divisor = '0;
   logic signed [W-1:0] quotient;
   logic                exception;
   logic                resultRDY;
   logic                busy;
   logic [4:0]          state_count;
`ifdef DIV_REMAINDER_EN
   logic signed [W-1:0] remainder;
`endif

   int checks = 0;
   int errors = 0;

   divider #(.WIDTH(W)) dut (
      .clock(clock),
      .reset(reset),
      .ctrl_div(ctrl_div),
      .dividend(dividend),
      .divisor(divisor),
      .quotient(quotient),
      .exception(exception),
      .resultRDY(resultRDY),
      .busy(busy),
      .state_count(state_count)
`ifdef DIV_REMAINDER_EN
      ,
      .remainder(remainder)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Counts edges after the start edge until resultRDY is seen, bounded.
   task automatic wait_rdy(output int n);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (resultRDY !== 1'b1 && n < 100);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] eq, input logic eexc,
                         input logic [31:0] erem);
      int n;
      @(negedge clock);
      dividend = a;
      divisor  = b;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1 ctrl_div = 1'b0;
      check({tag, " busy_after_start"}, {31'b0, busy}, 32'd1);
      if (!eexc) check({tag, " exc_cleared_on_start"}, {31'b0, exception}, 32'd0);
      wait_rdy(n);
      check({tag, " latency"}, n, lat);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " exception"}, {31'b0, exception}, {31'b0, eexc});
      check({tag, " busy_at_rdy"}, {31'b0, busy}, 32'd1);
`ifdef DIV_REMAINDER_EN
      check({tag, " remainder"}, remainder, erem);
`else
      if (erem !== erem) check({tag, " remainder_x"}, erem, 32'd0);
`endif
      @(posedge clock);
      #1;
      check({tag, " rdy_one_cycle"}, {31'b0, resultRDY}, 32'd0);
      check({tag, " idle_after"}, {31'b0, busy}, 32'd0);
      check({tag, " quotient_held"}, quotient, eq);
      check({tag, " exception_held"}, {31'b0, exception}, {31'b0, eexc});
   endtask

   initial begin
      int  n;
      bit  seen;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check("reset quotient", quotient, 32'd0);
      check("reset exception", {31'b0, exception}, 32'd0);
      check("reset resultRDY", {31'b0, resultRDY}, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset state_count", {27'b0, state_count}, 32'd0);
      @(negedge clock);
      reset = 1'b1;

      run_op("7/2",      32'd7,          32'd2,          33, 32'd3,          1'b0, 32'd1);
      run_op("-15/4",    -32'sd15,       32'd4,          33, 32'hFFFFFFFD,   1'b0, 32'hFFFFFFFD);
      run_op("-355/-71", -32'sd355,      -32'sd71,       33, 32'd5,          1'b0, 32'd0);
      run_op("0/9",      32'd0,          32'd9,          33, 32'd0,          1'b0, 32'd0);
      run_op("div0",     32'd12345,      32'd0,          1,  32'd0,          1'b1, 32'd0);
      run_op("ovf",      32'h80000000,   32'hFFFFFFFF,   1,  32'h80000000,   1'b1, 32'd0);
      run_op("min/2",    32'h80000000,   32'd2,          33, 32'hC0000000,   1'b0, 32'd0);
      run_op("-7/2",     -32'sd7,        32'd2,          33, 32'hFFFFFFFD,   1'b0, 32'hFFFFFFFF);

      // Start 100/7, then a second start mid-run must be ignored
      @(negedge clock);
      dividend = 32'd100;
      divisor  = 32'd7;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1 ctrl_div = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      dividend = 32'd1;
      divisor  = 32'd1;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1 ctrl_div = 1'b0;
      check("ign state_count", {27'b0, state_count}, 32'd10);
      wait_rdy(n);
      check("ign latency", n, 23);
      check("ign quotient", quotient, 32'd14);
`ifdef DIV_REMAINDER_EN
      check("ign remainder", remainder, 32'd2);
`endif
      // Pulse during the result-strobe cycle is ignored
      @(negedge clock);
      dividend = 32'd5;
      divisor  = 32'd5;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1 ctrl_div = 1'b0;
      check("rdy_cycle_start ignored", {31'b0, busy}, 32'd0);
      check("rdy_cycle quotient held", quotient, 32'd14);
      // Start in the cycle after the strobe is accepted
      run_op("20/-6",    32'd20,         -32'sd6,        33, 32'hFFFFFFFD,   1'b0, 32'd2);

      // Reset in the middle of 1000/3
      @(negedge clock);
      dividend = 32'd1000;
      divisor  = 32'd3;
      ctrl_div = 1'b1;
      @(posedge clock);
      #1 ctrl_div = 1'b0;
      repeat (20) @(posedge clock);
      #1;
      check("pre_reset state_count", {27'b0, state_count}, 32'd20);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check("midrst quotient", quotient, 32'd0);
      check("midrst exception", {31'b0, exception}, 32'd0);
      check("midrst resultRDY", {31'b0, resultRDY}, 32'd0);
      check("midrst busy", {31'b0, busy}, 32'd0);
      check("midrst state_count", {27'b0, state_count}, 32'd0);
`ifdef DIV_REMAINDER_EN
      check("midrst remainder", remainder, 32'd0);
`endif
      @(negedge clock);
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (resultRDY === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("midrst no_result", {31'b0, seen}, 32'd0);
      run_op("9/3",      32'd9,          32'd3,          33, 32'd3,          1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
